vga_pattern_sequencer: RTL and testbench
========================================

# vga_pattern_sequencer

Frame-synchronous test-pattern controller for the 640x480 VGA output path. Consumes the pixel coordinates, display-enable and vertical sync produced by the VGA timing generator, and drives the 4-bit red/green/blue channels. Steps through four built-in patterns, switching only on frame boundaries, on a push-button request and (optionally) automatically every N frames. Sits between the timing generator and the top-level colour outputs, replacing fixed colour registers.

## Interface
- FRAMES_PER_PATTERN, 120, frames shown per pattern in auto mode (1..255)
- i_clk  input  1  system clock (CLK100MHZ)
- i_rst_n  input  1  asynchronous active-low reset
- i_next_x  input  10  next pixel column from timing generator
- i_next_y  input  10  next pixel row from timing generator
- i_disp_en  input  1  active-video flag from timing generator
- i_vs  input  1  vertical sync, active low
- i_btn  input  1  advance button, asynchronous, debounced externally, active high
- o_red  output  4  red channel
- o_green  output  4  green channel
- o_blue  output  4  blue channel
- o_pattern  output  2  currently displayed pattern index
- o_frame_tick  output  1  one-cycle pulse at each frame boundary

## Operation
- One clock; reset is asynchronous and active-low.
- Pattern state machine, 2-bit, states in order: SOLID(0) -> BARS(1) -> CHECKER(2) -> GRADIENT(3) -> SOLID (wrap). o_pattern reflects the state.
- Frame boundary: falling edge of i_vs, detected against a 1-cycle registered copy of i_vs; o_frame_tick asserted for that one cycle.
- i_btn passes through a 2-flop synchronizer; a rising edge of the synchronized signal sets a pending flag. Further edges while pending have no additional effect (one advance per frame maximum).
- At a frame boundary with pending set: advance pattern, clear pending, clear frame counter.
- Colour generation (for the coordinate inputs, x = i_next_x, y = i_next_y):
  - SOLID: R=F, G=0, B=0.
  - BARS: i = x[8:6]; R={4{i[2]}}, G={4{i[1]}}, B={4{i[0]}}; bars 64 px wide, index repeats from x=512.
  - CHECKER: (x[5]^y[5]) ? all F : all 0; 32 px squares.
  - GRADIENT: R=x[9:6], G=y[8:5], B=0.
- When i_disp_en is low, all colour outputs are 0 regardless of pattern.
- Pattern changes never occur mid-frame; colour logic uses the registered pattern state only.

## Timing
- Reset values: o_red/o_green/o_blue=0, o_pattern=0 (SOLID), o_frame_tick=0, frame counter=0, pending=0, synchronizer and vs-edge registers=1 for i_vs copy, 0 for button.
- Colour outputs registered: latency exactly 1 i_clk from i_next_x/i_next_y/i_disp_en to o_red/o_green/o_blue.
- Frame-boundary detect: o_frame_tick high in the cycle after i_vs is sampled low following a high sample; pattern update takes effect on the same edge that raises o_frame_tick; first pixel using the new pattern is registered one cycle later.
- Button latency: edge on i_btn sets pending 3 cycles later (2 sync + edge detect); a button edge detected in the same cycle as a frame boundary is honored at the next frame boundary, not the current one.
- Reset mid-frame: all state returns to reset values immediately; no pending request survives.

## Configuration
- VGA_PATSEQ_AUTO_EN defined: 8-bit frame counter increments at every frame boundary; when it equals FRAMES_PER_PATTERN-1 at a boundary, pattern advances and counter clears. Manual advance at that boundary still produces a single advance and clears the counter.
- Not defined: no frame counter; pattern changes only via i_btn. FRAMES_PER_PATTERN ignored.

## Test plan
- Reset then i_disp_en=1, x=0,y=0 -> after 1 cycle R=F,G=0,B=0, o_pattern=0; with i_disp_en=0 -> all colours 0.
- Pulse i_btn mid-frame -> o_pattern stays 0 until next i_vs falling edge, then 1; x=448 (i=7) -> R=G=B=F; x=64 -> R=0,G=0,B=F.
- Two i_btn pulses in one frame -> exactly one advance at the boundary (o_pattern 1, not 2).
- Advance to CHECKER: x=32,y=0 -> all F; x=32,y=32 -> all 0. Advance to GRADIENT: x=639,y=479 -> R=9,G=E,B=0; one more advance wraps to SOLID.
- VGA_PATSEQ_AUTO_EN, FRAMES_PER_PATTERN=3: no button -> o_pattern changes on the 3rd, 6th, 9th o_frame_tick; button press before 2nd tick -> advance at 2nd tick, next auto advance at 5th.
- Assert i_rst_n low mid-frame with pending set -> all outputs 0, o_pattern=0 immediately; after release, next boundary causes no advance.

Source files
------------

// File: rtl/vga_pattern_sequencer.sv
// vga_pattern_sequencer: frame-synchronous VGA test-pattern controller.
// Cycles SOLID -> BARS -> CHECKER -> GRADIENT. The pattern changes only at a
// frame boundary, which is the falling edge of i_vs. A button press requests
// the change. When VGA_PATSEQ_AUTO_EN is defined, the pattern also advances
// every FRAMES_PER_PATTERN frames.
// The colour outputs are registered one cycle behind the coordinate inputs.
module vga_pattern_sequencer #(
    parameter int FRAMES_PER_PATTERN = 120
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [9:0] i_next_x,
    input  logic [9:0] i_next_y,
    input  logic       i_disp_en,
    input  logic       i_vs,
    input  logic       i_btn,
    output logic [3:0] o_red,
    output logic [3:0] o_green,
    output logic [3:0] o_blue,
    output logic [1:0] o_pattern,
    output logic       o_frame_tick
);

    typedef enum logic [1:0] {
        SOLID    = 2'd0,
        BARS     = 2'd1,
        CHECKER  = 2'd2,
        GRADIENT = 2'd3
    } pattern_t;

    pattern_t   pattern;
    logic       vs_q;
    logic       btn_s1;
    logic       btn_s2;
    logic       btn_s3;
    logic       pending;
    logic       frame_edge;
    logic       btn_rise;
    logic       advance;
    logic [2:0] bar;
    logic       checker_on;
    logic [3:0] red_d;
    logic [3:0] green_d;
    logic [3:0] blue_d;
    logic       unused_bits;

    assign frame_edge = vs_q & ~i_vs;
    assign btn_rise   = btn_s2 & ~btn_s3;
    assign bar        = i_next_x[8:6];
    assign checker_on = i_next_x[5] ^ i_next_y[5];
    assign o_pattern  = pattern;

`ifdef VGA_PATSEQ_AUTO_EN
    localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_PATTERN - 1);

    logic [7:0] frame_count;

    assign advance     = pending | (frame_count == LAST_FRAME);
    assign unused_bits = ^{i_next_x[4:0], i_next_y[9], i_next_y[4:0]};

    // Count frames shown in the current pattern; any advance restarts the count
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_count <= 8'd0;
        end else if (frame_edge) begin
            if (advance) begin
                frame_count <= 8'd0;
            end else begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end
`else
    assign advance     = pending;
    assign unused_bits = ^{i_next_x[4:0], i_next_y[9], i_next_y[4:0],
                           8'(FRAMES_PER_PATTERN)};
`endif

    // Delay vs by one cycle for edge detection; synchronize the button and keep its last value
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vs_q   <= 1'b1;
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            btn_s3 <= 1'b0;
        end else begin
            vs_q   <= i_vs;
            btn_s1 <= i_btn;
            btn_s2 <= btn_s1;
            btn_s3 <= btn_s2;
        end
    end

    // Pattern state machine: advance only at a frame boundary.
    // A press arriving in the boundary cycle is held for the next frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pattern      <= SOLID;
            pending      <= 1'b0;
            o_frame_tick <= 1'b0;
        end else begin
            o_frame_tick <= frame_edge;
            if (frame_edge) begin
                if (advance) begin
                    pattern <= pattern_t'(pattern + 2'd1);
                end
                pending <= btn_rise;
            end else if (btn_rise) begin
                pending <= 1'b1;
            end
        end
    end

    // Colour for the upcoming pixel from the registered pattern; blank outside active video
    always_comb begin
        red_d   = 4'h0;
        green_d = 4'h0;
        blue_d  = 4'h0;
        if (i_disp_en) begin
            case (pattern)
                SOLID: begin
                    red_d = 4'hF;
                end
                BARS: begin
                    red_d   = {4{bar[2]}};
                    green_d = {4{bar[1]}};
                    blue_d  = {4{bar[0]}};
                end
                CHECKER: begin
                    red_d   = {4{checker_on}};
                    green_d = {4{checker_on}};
                    blue_d  = {4{checker_on}};
                end
                GRADIENT: begin
                    red_d   = i_next_x[9:6];
                    green_d = i_next_y[8:5];
                end
                default: begin
                    red_d = 4'h0;
                end
            endcase
        end
    end

    // Register the colour outputs so they appear one clock after the coordinates
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_red   <= 4'h0;
            o_green <= 4'h0;
            o_blue  <= 4'h0;
        end else begin
            o_red   <= red_d;
            o_green <= green_d;
            o_blue  <= blue_d;
        end
    end

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// tb_vga_pattern_sequencer: self-checking bench for vga_pattern_sequencer.
// The bench uses table vectors, hand-written frame sequences and a randomized run.
// All three are checked against an integer reference model.
// Honours VGA_PATSEQ_AUTO_EN with FRAMES_PER_PATTERN = 3.
module tb_vga_pattern_sequencer;

    localparam int FPP = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [9:0] next_x = '0;
    logic [9:0] next_y = '0;
    logic       disp_en = 1'b0;
    logic       vs = 1'b1;
    logic       btn = 1'b0;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic [1:0] pattern;
    logic       frame_tick;

    int compared = 0;
    int mismatched = 0;

    // reference model state
    int  model_pat;
    bit  model_pending;
    int  model_frames;
    bit  model_prev_vs;
    bit  btn_hist[$];
    int  exp_r, exp_g, exp_b;
    bit  exp_tick;

    typedef struct {
        int   pat;
        int   x;
        int   y;
        bit   en;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } vec_t;

    vec_t vecs[$];

    vga_pattern_sequencer #(.FRAMES_PER_PATTERN(FPP)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_next_x    (next_x),
        .i_next_y    (next_y),
        .i_disp_en   (disp_en),
        .i_vs        (vs),
        .i_btn       (btn),
        .o_red       (red),
        .o_green     (green),
        .o_blue      (blue),
        .o_pattern   (pattern),
        .o_frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Expected colour of one pixel, derived arithmetically from the pattern rules
    function automatic logic [11:0] ref_colour(input int pat, input int x, input int y, input bit en);
        int r, g, b, i;
        r = 0; g = 0; b = 0;
        if (en) begin
            case (pat)
                0: r = 15;
                1: begin
                    i = (x / 64) % 8;
                    r = ((i / 4) % 2) ? 15 : 0;
                    g = ((i / 2) % 2) ? 15 : 0;
                    b = (i % 2) ? 15 : 0;
                end
                2: begin
                    if (((x / 32) + (y / 32)) % 2 == 1) begin
                        r = 15; g = 15; b = 15;
                    end
                end
                default: begin
                    r = (x / 64) % 16;
                    g = (y / 32) % 16;
                end
            endcase
        end
        return {4'(r), 4'(g), 4'(b)};
    endfunction

    task automatic model_reset();
        model_pat     = 0;
        model_pending = 0;
        model_frames  = 0;
        model_prev_vs = 1;
        btn_hist.delete();
        repeat (3) btn_hist.push_back(1'b0);
        exp_r = 0; exp_g = 0; exp_b = 0;
        exp_tick = 0;
    endtask

    // One clock of the reference model, called at each rising edge with the inputs just sampled
    task automatic model_update();
        logic [11:0] c;
        bit boundary, rise, adv;
        c = ref_colour(model_pat, int'(next_x), int'(next_y), disp_en);
        exp_r = int'(c[11:8]);
        exp_g = int'(c[7:4]);
        exp_b = int'(c[3:0]);
        boundary = model_prev_vs && !vs;
        exp_tick = boundary;
        rise = btn_hist[1] && !btn_hist[0];
        if (boundary) begin
            adv = model_pending;
`ifdef VGA_PATSEQ_AUTO_EN
            if (model_frames == FPP - 1) adv = 1;
`endif
            if (adv) begin
                model_pat = (model_pat + 1) % 4;
                model_frames = 0;
            end else begin
                model_frames++;
            end
            model_pending = rise;
        end else if (rise) begin
            model_pending = 1;
        end
        model_prev_vs = vs;
        btn_hist.push_back(btn);
        void'(btn_hist.pop_front());
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        model_update();
        #1;
        checkOutput();
    endtask

    task automatic checkOutput();
        check("model.red", red, exp_r);
        check("model.green", green, exp_g);
        check("model.blue", blue, exp_b);
        check("model.pattern", pattern, model_pat);
        check("model.frame_tick", frame_tick, exp_tick);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset.red", red, 0);
        check("reset.green", green, 0);
        check("reset.blue", blue, 0);
        check("reset.pattern", pattern, 0);
        check("reset.frame_tick", frame_tick, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic press_button();
        btn = 1'b1;
        repeat (2) applyStimulus();
        btn = 1'b0;
        repeat (4) applyStimulus();
    endtask

    task automatic frame();
        vs = 1'b0;
        repeat (2) applyStimulus();
        vs = 1'b1;
        applyStimulus();
    endtask

    task automatic advance_to(input int target);
        int guard;
        guard = 0;
        while (model_pat != target && guard < 8) begin
            press_button();
            frame();
            guard++;
        end
        check("advance_to.pattern", pattern, target);
    endtask

    initial begin
        #2;
        do_reset();

        // table vectors grouped by pattern, with the final entry checking wrap to SOLID
        vecs.push_back('{0, 0,   0,   1'b1, 4'hF, 4'h0, 4'h0});
        vecs.push_back('{0, 100, 50,  1'b0, 4'h0, 4'h0, 4'h0});
        vecs.push_back('{1, 448, 0,   1'b1, 4'hF, 4'hF, 4'hF});
        vecs.push_back('{1, 64,  0,   1'b1, 4'h0, 4'h0, 4'hF});
        vecs.push_back('{1, 200, 0,   1'b1, 4'h0, 4'hF, 4'hF});
        vecs.push_back('{1, 600, 10,  1'b1, 4'h0, 4'h0, 4'hF});
        vecs.push_back('{2, 32,  0,   1'b1, 4'hF, 4'hF, 4'hF});
        vecs.push_back('{2, 32,  32,  1'b1, 4'h0, 4'h0, 4'h0});
        vecs.push_back('{2, 0,   0,   1'b1, 4'h0, 4'h0, 4'h0});
        vecs.push_back('{3, 639, 479, 1'b1, 4'h9, 4'hE, 4'h0});
        vecs.push_back('{3, 130, 70,  1'b1, 4'h2, 4'h2, 4'h0});
        vecs.push_back('{3, 639, 479, 1'b0, 4'h0, 4'h0, 4'h0});
        vecs.push_back('{0, 5,   5,   1'b1, 4'hF, 4'h0, 4'h0});

        for (int i = 0; i < vecs.size(); i++) begin
            advance_to(vecs[i].pat);
            next_x  = 10'(vecs[i].x);
            next_y  = 10'(vecs[i].y);
            disp_en = vecs[i].en;
            applyStimulus();
            check("vec.red", red, vecs[i].r);
            check("vec.green", green, vecs[i].g);
            check("vec.blue", blue, vecs[i].b);
            check("vec.pattern", pattern, vecs[i].pat);
        end

        // mid-frame press waits for the vs falling edge
        do_reset();
        press_button();
        repeat (3) applyStimulus();
        check("btn.hold_pattern", pattern, 0);
        vs = 1'b0;
        applyStimulus();
        check("btn.frame_tick", frame_tick, 1);
        check("btn.new_pattern", pattern, 1);
        vs = 1'b1;
        applyStimulus();
        check("btn.tick_clear", frame_tick, 0);

        // two presses in one frame give a single advance
        do_reset();
        press_button();
        press_button();
        frame();
        check("double.pattern", pattern, 1);

        // a press detected in the boundary cycle is held for the next frame
        do_reset();
        btn = 1'b1;
        repeat (2) applyStimulus();
        vs = 1'b0;
        applyStimulus();
        check("coincide.now", pattern, 0);
        btn = 1'b0;
        vs = 1'b1;
        repeat (3) applyStimulus();
        frame();
        check("coincide.next", pattern, 1);

`ifdef VGA_PATSEQ_AUTO_EN
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            frame();
            check("auto.pattern", pattern, (k / 3) % 4);
        end
        do_reset();
        frame();
        press_button();
        frame();
        check("auto.btn_tick2", pattern, 1);
        frame();
        frame();
        check("auto.btn_tick4", pattern, 1);
        frame();
        check("auto.btn_tick5", pattern, 2);
`endif

        // asynchronous reset mid-frame discards a pending request
        do_reset();
        advance_to(1);
        next_x = 10'd448;
        disp_en = 1'b1;
        applyStimulus();
        check("midreset.before", red, 15);
        press_button();
        do_reset();
        frame();
        check("midreset.no_advance", pattern, 0);

        // randomized run against the model
        for (int c = 0; c < 800; c++) begin
            next_x  = 10'($urandom_range(0, 639));
            next_y  = 10'($urandom_range(0, 479));
            disp_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) btn = ~btn;
            vs = ((c % 16) < 2) ? 1'b0 : 1'b1;
            applyStimulus();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
